i2c_target_fsm: RTL and testbench
=================================

// Module: i2c_target_fsm
// PURPOSE
// - Oversampled I2C target protocol engine. Syncs SCL/SDA into clk, detects START/STOP, shifts address/data bits, runs the transaction FSM.
// - Its state code and bit index feed the negedge-SCL SDA drive stage. Its write/read strobes talk to the PID register file.
// - Pure sampler: never drives SCL or SDA itself.
// PARAMETERS
// - DEV_ADDR  7'h2A  7-bit target address matched in DEVICE_ADDR.
// - DATA_W    8      register data width; reg address is also 8 bits.
// PORTS
// - clk         in   1       system clock; the only clock.
// - rst         in   1       asynchronous, active-high reset.
// - ena         in   1       block enable; low forces IDLE (sync), holds outputs.
// - SCL_in      in   1       raw SCL pad input (asynchronous).
// - SDA_in      in   1       raw SDA pad input (asynchronous).
// - rd_data     in   DATA_W  register value at reg_addr; sampled on rd_strobe+1.
// - state       out  5       0 IDLE,1 START,2 DEVICE_ADDR,3 READ_OR_WRITE,4 ADDR_ACK,5 REG_ADDR,6 REG_ACK,7 WRITE,8 WRITE_ACK,9 READ,10 READ_ACK,11 STOP.
// - data_index  out  3       bit position of current data bit, MSB first.
// - read_value  out  DATA_W  latched byte being shifted to master.
// - reg_addr    out  8       register pointer.
// - wr_data     out  DATA_W  received data byte.
// - wr_strobe   out  1       1-clk pulse: write wr_data to reg_addr.
// - rd_strobe   out  1       1-clk pulse: present rd_data for reg_addr.
// - addr_match  out  1       high from a matching address until STOP/START.
// BEHAVIOUR
// - Reset: state=IDLE, data_index=0, read_value=0, reg_addr=0, wr_data=0, strobes=0, addr_match=0. Synchronizers reset to 1 (bus idle).
// - Input path: 2-FF sync per line plus 1 history reg. An edge is seen 3 clk after the pin; state updates at edge+1 clk.
// - START: SDA fall while SCL high -> START from any state (repeated start included). Clears addr_match.
// - STOP: SDA rise while SCL high -> STOP for exactly 1 clk -> IDLE.
// - Simultaneous SCL and SDA change in one sample: treated as SCL edge only; no START/STOP.
// - Bits are sampled on SCL rise. State/index advance on SCL fall.
// - START: first SCL fall -> DEVICE_ADDR, data_index=6.
// - DEVICE_ADDR: sample bit; fall decrements index; fall at index 0 -> READ_OR_WRITE.
// - READ_OR_WRITE: sample R/W. On fall: address match -> ADDR_ACK, addr_match=1; mismatch -> IDLE (ignore until next START).
// - ADDR_ACK, on fall: R/W=0 -> REG_ADDR, index=7. R/W=1 -> READ, index=7, rd_strobe pulses 1 clk after the fall.
// - REG_ADDR: 8 bits MSB first into shift reg. Fall at index 0 -> REG_ACK, reg_addr loaded.
// - REG_ACK, on fall: -> WRITE, index=7.
// - WRITE: 8 bits. Fall at index 0 -> WRITE_ACK, wr_data loaded, wr_strobe pulses at the same clk.
// - WRITE_ACK, on fall: -> WRITE, index=7 (multi-byte write).
// - READ: read_value latched from rd_data 1 clk after rd_strobe; it must be stable before the next SCL fall. Fall at index 0 -> READ_ACK.
// - READ_ACK: sample master SDA on rise. On fall: 0 (ACK) -> READ, index=7, rd_strobe pulses; 1 (NACK) -> IDLE.
// - data_index wraps 0->7 only via the explicit reloads above; never free-runs.
// - ena low: next clk state=IDLE, strobes=0; regs hold. Resume only after a new START.
// - Reset mid-transfer: immediate async return to reset values; the bus transaction is abandoned.
// CONFIGURATION
// - I2C_AUTO_INC_EN defined: reg_addr += 1 (mod 256) 1 clk after each wr_strobe and after each ACKed READ_ACK. This allows burst access.
// - I2C_AUTO_INC_EN undefined: reg_addr changes only in REG_ADDR; bursts re-access the same register.
// TESTING
// - Write 0x2A/W, reg 0x05, data 0x3C -> state path 1,2,3,4,5,6,7,8; one wr_strobe with reg_addr=0x05, wr_data=0x3C.
// - Address 0x11/W -> IDLE after READ_OR_WRITE; addr_match=0; no strobes; next START re-engages.
// - Read 0x2A/R with rd_data=0x96, master NACK -> rd_strobe once, read_value=0x96, data_index 7..0, then IDLE; STOP gives 1-clk STOP.
// - Burst write 0x01,0x02 to reg 0x10 -> two wr_strobes; with I2C_AUTO_INC_EN reg_addr 0x10 then 0x11, without it 0x10 both.
// - Repeated START during WRITE index 3 -> state=START; addr_match=0; no wr_strobe for partial byte.
// - Assert rst while in READ index 4 -> all outputs zero immediately; after release a full write transaction succeeds.

Source files
------------

// File: rtl/i2c_target_fsm.sv
// ---------------------------------------------------------------------------------------------
// i2c_target_fsm
//
// Oversampled I2C target protocol engine. SCL/SDA are synchronised into clk, START/STOP are
// detected, address/data bits are shifted in on SCL rise and the transaction FSM advances on
// SCL fall. The state code and data_index feed a separate negedge-SCL SDA drive stage; the
// write/read strobes talk to a register file. This block only samples the bus, never drives it.
//
// Optional feature: define I2C_AUTO_INC_EN to post-increment reg_addr (mod 256) one clk after
// each wr_strobe and on each ACKed READ_ACK, for burst access.
//
// Parameters
//   DEV_ADDR    7-bit target address
//   DATA_W      register data width (the bit counter assumes 8)
// Ports
//   clk         system clock
//   rst         asynchronous active-high reset
//   ena         block enable; low forces IDLE and clears strobes, registers hold
//   SCL_in      raw SCL pad input (asynchronous)
//   SDA_in      raw SDA pad input (asynchronous)
//   rd_data     register value at reg_addr, captured the clk after rd_strobe
//   state       FSM state code (0 IDLE .. 11 STOP)
//   data_index  current bit position, MSB first
//   read_value  byte being shifted out to the master
//   reg_addr    register pointer
//   wr_data     last received data byte
//   wr_strobe   1-clk pulse: write wr_data to reg_addr
//   rd_strobe   1-clk pulse: request rd_data for reg_addr
//   addr_match  high from a matching address until the next START/STOP
// ---------------------------------------------------------------------------------------------
module i2c_target_fsm #(
    parameter logic [6:0]  DEV_ADDR = 7'h2A,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              SCL_in,
    input  logic              SDA_in,
    input  logic [DATA_W-1:0] rd_data,
    output logic [4:0]        state,
    output logic [2:0]        data_index,
    output logic [DATA_W-1:0] read_value,
    output logic [7:0]        reg_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_strobe,
    output logic              rd_strobe,
    output logic              addr_match
);

    typedef enum logic [4:0] {
        StIdle     = 5'd0,
        StStart    = 5'd1,
        StDevAddr  = 5'd2,
        StRw       = 5'd3,
        StAddrAck  = 5'd4,
        StRegAddr  = 5'd5,
        StRegAck   = 5'd6,
        StWrite    = 5'd7,
        StWriteAck = 5'd8,
        StRead     = 5'd9,
        StReadAck  = 5'd10,
        StStop     = 5'd11
    } state_e;

    state_e state_q, state_d;

    // Input synchronisers; reset to 1 so a reset looks like an idle bus.
    logic scl_meta, scl_sync, scl_hist;
    logic sda_meta, sda_sync, sda_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_hist <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_meta <= SCL_in;
            scl_sync <= scl_meta;
            scl_hist <= scl_sync;
            sda_meta <= SDA_in;
            sda_sync <= sda_meta;
            sda_hist <= sda_sync;
        end
    end

    logic scl_rise, scl_fall, scl_steady_hi, start_det, stop_det;

    assign scl_rise      = scl_sync & ~scl_hist;
    assign scl_fall      = ~scl_sync & scl_hist;
    // SDA edges only count as START/STOP when SCL did not move in the same sample.
    assign scl_steady_hi = scl_sync & scl_hist;
    assign start_det     = scl_steady_hi & ~sda_sync & sda_hist;
    assign stop_det      = scl_steady_hi & sda_sync & ~sda_hist;

    // Datapath registers
    logic [2:0]        idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] read_value_q, read_value_d;
    logic [7:0]        reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic              rd_req_q, rd_req_d;
    logic              rd_strobe_q, rd_strobe_d;
    logic              addr_match_q, addr_match_d;
    logic              rw_q, rw_d;
    logic              ack_q, ack_d;
    logic              dev_match;

    assign dev_match = (shift_q[6:0] == DEV_ADDR);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!ena) begin
            state_d = StIdle;
        end else if (start_det) begin
            state_d = StStart;
        end else if (stop_det) begin
            state_d = StStop;
        end else begin
            unique case (state_q)
                StIdle:     state_d = StIdle;
                StStart:    if (scl_fall) state_d = StDevAddr;
                StDevAddr:  if (scl_fall && idx_q == 3'd0) state_d = StRw;
                StRw:       if (scl_fall) state_d = dev_match ? StAddrAck : StIdle;
                StAddrAck:  if (scl_fall) state_d = rw_q ? StRead : StRegAddr;
                StRegAddr:  if (scl_fall && idx_q == 3'd0) state_d = StRegAck;
                StRegAck:   if (scl_fall) state_d = StWrite;
                StWrite:    if (scl_fall && idx_q == 3'd0) state_d = StWriteAck;
                StWriteAck: if (scl_fall) state_d = StWrite;
                StRead:     if (scl_fall && idx_q == 3'd0) state_d = StReadAck;
                StReadAck:  if (scl_fall) state_d = ack_q ? StIdle : StRead;
                StStop:     state_d = StIdle;
                default:    state_d = StIdle;
            endcase
        end
    end

    // Output / datapath next-state logic
    always_comb begin
        idx_d        = idx_q;
        shift_d      = shift_q;
        read_value_d = read_value_q;
        reg_addr_d   = reg_addr_q;
        wr_data_d    = wr_data_q;
        wr_strobe_d  = 1'b0;
        rd_req_d     = 1'b0;
        rd_strobe_d  = 1'b0;
        addr_match_d = addr_match_q;
        rw_d         = rw_q;
        ack_d        = ack_q;

        if (ena) begin
            // rd_strobe trails the triggering fall by one clk; data is captured one clk later.
            rd_strobe_d = rd_req_q;
            if (rd_strobe_q) begin
                read_value_d = rd_data;
            end
`ifdef I2C_AUTO_INC_EN
            if (wr_strobe_q) begin
                reg_addr_d = reg_addr_q + 8'd1;
            end
`endif
            if (start_det || stop_det) begin
                addr_match_d = 1'b0;
                rd_req_d     = 1'b0;
                rd_strobe_d  = 1'b0;
            end else begin
                unique case (state_q)
                    StStart: begin
                        if (scl_fall) idx_d = 3'd6;
                    end
                    StDevAddr: begin
                        if (scl_rise) shift_d = {shift_q[DATA_W-2:0], sda_sync};
                        if (scl_fall && idx_q != 3'd0) idx_d = idx_q - 3'd1;
                    end
                    StRw: begin
                        if (scl_rise) rw_d = sda_sync;
                        if (scl_fall && dev_match) addr_match_d = 1'b1;
                    end
                    StAddrAck: begin
                        if (scl_fall) begin
                            idx_d    = 3'd7;
                            rd_req_d = rw_q;
                        end
                    end
                    StRegAddr: begin
                        if (scl_rise) shift_d = {shift_q[DATA_W-2:0], sda_sync};
                        if (scl_fall) begin
                            if (idx_q == 3'd0) reg_addr_d = shift_q[7:0];
                            else               idx_d      = idx_q - 3'd1;
                        end
                    end
                    StRegAck, StWriteAck: begin
                        if (scl_fall) idx_d = 3'd7;
                    end
                    StWrite: begin
                        if (scl_rise) shift_d = {shift_q[DATA_W-2:0], sda_sync};
                        if (scl_fall) begin
                            if (idx_q == 3'd0) begin
                                wr_data_d   = shift_q;
                                wr_strobe_d = 1'b1;
                            end else begin
                                idx_d = idx_q - 3'd1;
                            end
                        end
                    end
                    StRead: begin
                        if (scl_fall && idx_q != 3'd0) idx_d = idx_q - 3'd1;
                    end
                    StReadAck: begin
                        if (scl_rise) ack_d = sda_sync;
                        if (scl_fall && !ack_q) begin
                            idx_d    = 3'd7;
                            rd_req_d = 1'b1;
`ifdef I2C_AUTO_INC_EN
                            reg_addr_d = reg_addr_q + 8'd1;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= 3'd0;
            shift_q      <= '0;
            read_value_q <= '0;
            reg_addr_q   <= 8'd0;
            wr_data_q    <= '0;
            wr_strobe_q  <= 1'b0;
            rd_req_q     <= 1'b0;
            rd_strobe_q  <= 1'b0;
            addr_match_q <= 1'b0;
            rw_q         <= 1'b0;
            ack_q        <= 1'b1;
        end else begin
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            read_value_q <= read_value_d;
            reg_addr_q   <= reg_addr_d;
            wr_data_q    <= wr_data_d;
            wr_strobe_q  <= wr_strobe_d;
            rd_req_q     <= rd_req_d;
            rd_strobe_q  <= rd_strobe_d;
            addr_match_q <= addr_match_d;
            rw_q         <= rw_d;
            ack_q        <= ack_d;
        end
    end

    assign state      = state_q;
    assign data_index = idx_q;
    assign read_value = read_value_q;
    assign reg_addr   = reg_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_strobe  = wr_strobe_q;
    assign rd_strobe  = rd_strobe_q;
    assign addr_match = addr_match_q;

endmodule

// File: tb/tb_i2c_target_fsm.sv
// Testbench for i2c_target_fsm: bit-banged I2C master, scoreboard of expected strobes and a
// trace of FSM state changes.
module tb_i2c_target_fsm;

    localparam int Q = 6;  // clk cycles per quarter SCL period
`ifdef I2C_AUTO_INC_EN
    localparam bit AutoInc = 1'b1;
`else
    localparam bit AutoInc = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       scl;
    logic       sda;
    logic [7:0] rd_data;
    logic [4:0] state;
    logic [2:0] data_index;
    logic [7:0] read_value;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic       wr_strobe;
    logic       rd_strobe;
    logic       addr_match;

    always #5 clk = ~clk;

    i2c_target_fsm #(
        .DEV_ADDR (7'h2A),
        .DATA_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .SCL_in     (scl),
        .SDA_in     (sda),
        .rd_data    (rd_data),
        .state      (state),
        .data_index (data_index),
        .read_value (read_value),
        .reg_addr   (reg_addr),
        .wr_data    (wr_data),
        .wr_strobe  (wr_strobe),
        .rd_strobe  (rd_strobe),
        .addr_match (addr_match)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: {reg_addr, wr_data} per expected write, reg_addr per expected read request.
    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic [4:0]  trace[$];
    logic [4:0]  prev_state = 5'd0;
    int          stop_len = 0;
    logic [15:0] wr_exp;
    logic [7:0]  rd_exp;

    always @(negedge clk) begin
        if (rst) begin
            prev_state = 5'd0;
            stop_len   = 0;
        end else begin
            if (wr_strobe) begin
                if (wr_q.size() == 0) begin
                    check_eq("wr_unexpected", {31'd0, wr_strobe}, 32'd0);
                end else begin
                    wr_exp = wr_q.pop_front();
                    check_eq("wr_reg_addr", reg_addr, wr_exp[15:8]);
                    check_eq("wr_data", wr_data, wr_exp[7:0]);
                end
            end
            if (rd_strobe) begin
                if (rd_q.size() == 0) begin
                    check_eq("rd_unexpected", {31'd0, rd_strobe}, 32'd0);
                end else begin
                    rd_exp = rd_q.pop_front();
                    check_eq("rd_reg_addr", reg_addr, rd_exp);
                end
            end
            if (state == 5'd11) begin
                stop_len++;
            end else if (stop_len != 0) begin
                check_eq("stop_len", stop_len, 1);
                stop_len = 0;
            end
            if (state != prev_state) trace.push_back(state);
            prev_state = state;
        end
    end

    // Expected trace packed as hex nibbles, first state in the most significant used nibble.
    task automatic check_trace(input string tag, input logic [63:0] exp, input int n);
        check_eq({tag, "_len"}, trace.size(), n);
        for (int i = 0; i < n && i < trace.size(); i++) begin
            check_eq(tag, trace[i], {28'd0, exp[4*(n-1-i) +: 4]});
        end
        trace.delete();
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start();
        sda = 1'b1; wait_clk(Q);
        scl = 1'b1; wait_clk(Q);
        sda = 1'b0; wait_clk(Q);
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda = 1'b0; wait_clk(Q);
        scl = 1'b1; wait_clk(Q);
        sda = 1'b1; wait_clk(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        sda = b;    wait_clk(Q);
        scl = 1'b1; wait_clk(2 * Q);
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_addr(input logic [6:0] a, input logic rw);
        for (int i = 6; i >= 0; i--) send_bit(a[i]);
        send_bit(rw);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; ena = 1'b1; scl = 1'b1; sda = 1'b1; rd_data = 8'h96;
        wait_clk(3);
        #1;
        check_eq("rst_state", state, 0);
        check_eq("rst_outputs", {data_index, read_value, reg_addr, wr_data, wr_strobe,
                                 rd_strobe, addr_match}, 0);
        @(posedge clk); #2 rst = 1'b0;
        wait_clk(5);
        trace.delete();

        // Single-byte write: 0x2A/W, reg 0x05, data 0x3C
        bus_start();
        send_addr(7'h2A, 1'b0);
        send_bit(1'b1);
        check_eq("wr_addr_match", addr_match, 1);
        send_byte(8'h05);
        send_bit(1'b1);
        wr_q.push_back({8'h05, 8'h3C});
        send_byte(8'h3C);
        send_bit(1'b1);
        bus_stop();
        check_trace("wr_path", 64'h123456787B0, 11);
        check_eq("wr_done", wr_q.size(), 0);
        check_eq("wr_addr_match_after_stop", addr_match, 0);

        // Address mismatch: ignored until the next START
        bus_start();
        send_addr(7'h11, 1'b0);
        check_eq("nomatch_state", state, 0);
        check_eq("nomatch_addr_match", addr_match, 0);
        send_bit(1'b1);
        send_byte(8'h55);
        bus_stop();
        check_trace("nomatch_path", 64'h1230B0, 6);

        // Read with master NACK
        rd_q.push_back(AutoInc ? 8'h06 : 8'h05);
        bus_start();
        send_addr(7'h2A, 1'b1);
        send_bit(1'b1);
        for (int k = 0; k < 8; k++) begin
            sda = 1'b1; wait_clk(Q);
            scl = 1'b1; wait_clk(Q);
            @(negedge clk);
            check_eq("rd_index", data_index, 7 - k);
            wait_clk(Q);
            scl = 1'b0; wait_clk(Q);
        end
        check_eq("rd_value", read_value, 8'h96);
        check_eq("rd_ack_state", state, 10);
        send_bit(1'b1);
        check_eq("rd_nack_state", state, 0);
        bus_stop();
        check_trace("rd_path", 64'h12349A0B0, 9);
        check_eq("rd_done", rd_q.size(), 0);

        // Burst write to reg 0x10
        wr_q.push_back({8'h10, 8'h01});
        wr_q.push_back({AutoInc ? 8'h11 : 8'h10, 8'h02});
        bus_start();
        send_addr(7'h2A, 1'b0);
        send_bit(1'b1);
        send_byte(8'h10);
        send_bit(1'b1);
        send_byte(8'h01);
        send_bit(1'b1);
        send_byte(8'h02);
        send_bit(1'b1);
        bus_stop();
        check_eq("burst_done", wr_q.size(), 0);
        check_eq("burst_reg_addr", reg_addr, AutoInc ? 8'h12 : 8'h10);
        trace.delete();

        // Repeated START during WRITE at index 3
        bus_start();
        send_addr(7'h2A, 1'b0);
        send_bit(1'b1);
        send_byte(8'h20);
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check_eq("rs_state_before", state, 7);
        check_eq("rs_index_before", data_index, 3);
        sda = 1'b1; wait_clk(Q);
        scl = 1'b1; wait_clk(Q);
        sda = 1'b0; wait_clk(Q);
        check_eq("rs_state", state, 1);
        check_eq("rs_addr_match", addr_match, 0);
        scl = 1'b0; wait_clk(Q);
        bus_stop();
        check_eq("rs_reg_addr", reg_addr, 8'h20);
        trace.delete();

        // Reset while in READ at index 4, then a full write
        rd_q.push_back(8'h20);
        bus_start();
        send_addr(7'h2A, 1'b1);
        send_bit(1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        check_eq("rstmid_state_before", state, 9);
        check_eq("rstmid_index_before", data_index, 4);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check_eq("rstmid_state", state, 0);
        check_eq("rstmid_outputs", {data_index, read_value, reg_addr, wr_data, wr_strobe,
                                    rd_strobe, addr_match}, 0);
        scl = 1'b1; sda = 1'b1;
        wait_clk(3);
        #2 rst = 1'b0;
        wait_clk(5);
        trace.delete();
        wr_q.push_back({8'h07, 8'hA5});
        bus_start();
        send_addr(7'h2A, 1'b0);
        send_bit(1'b1);
        send_byte(8'h07);
        send_bit(1'b1);
        send_byte(8'hA5);
        send_bit(1'b1);
        bus_stop();
        check_eq("post_rst_done", wr_q.size(), 0);
        check_eq("post_rst_reg_addr", reg_addr, AutoInc ? 8'h08 : 8'h07);
        trace.delete();

        // ena low mid-address: forced IDLE, stays there until a new START
        bus_start();
        for (int i = 6; i >= 4; i--) send_bit(1'b0);
        @(posedge clk); ena = 1'b0;
        wait_clk(2);
        check_eq("ena_low_state", state, 0);
        @(posedge clk); ena = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        check_eq("ena_resume_state", state, 0);
        check_eq("ena_addr_match", addr_match, 0);
        bus_stop();

        check_eq("final_wr_q", wr_q.size(), 0);
        check_eq("final_rd_q", rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
